// File: rtl/prng_stream_pkg.sv
// Shared types and the single-step Galois LFSR helper for the PRNG stream buffer.
package prng_stream_pkg;

    typedef enum logic {
        MODE_MANUAL   = 1'b0,
        MODE_AUTOFILL = 1'b1
    } mode_e;

    localparam int         LFSR_MAX_WIDTH    = 32;
    localparam logic [7:0] DEFAULT_LFSR_POLY = 8'hB8;

    typedef logic [LFSR_MAX_WIDTH-1:0] lfsr_word_t;

    typedef struct packed {
        lfsr_word_t state;
        logic       out_bit;
    } lfsr_step_t;

    // Narrower LFSRs ride in the low bits; zero upper bits stay zero because
    // the polynomial is zero-extended as well.
    function automatic lfsr_step_t lfsr_step(input lfsr_word_t state, input lfsr_word_t poly);
        lfsr_step_t r;
        r.out_bit = state[0];
        r.state   = state >> 1;
        if (state[0]) begin
            r.state = r.state ^ poly;
        end
        return r;
    endfunction

endpackage

// File: rtl/prng_stream_channel.sv
// One PRNG channel: Galois LFSR producing DATA_WIDTH bits per accepted push into
// a first-word-fall-through FIFO with occupancy count and sticky error flags.
module prng_stream_channel
    import prng_stream_pkg::*;
#(
    parameter int                    DATA_WIDTH = 4,
    parameter int                    FIFO_DEPTH = 16,
    parameter int                    LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(1),
    parameter logic [LFSR_WIDTH-1:0] POLY       = LFSR_WIDTH'(DEFAULT_LFSR_POLY),
    localparam int                   PW         = $clog2(FIFO_DEPTH),
    localparam int                   CW         = PW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  mode_e                 mode,
    input  logic                  gen_req,
    input  logic                  pop,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  full,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    if (SEED == '0) begin : g_bad_seed
        $error("prng_stream_channel: LFSR seed must be nonzero");
    end
    if ((1 << PW) != FIFO_DEPTH || FIFO_DEPTH < 2) begin : g_bad_depth
        $error("prng_stream_channel: FIFO_DEPTH must be a power of two >= 2");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > LFSR_WIDTH) begin : g_bad_width
        $error("prng_stream_channel: DATA_WIDTH must be in 1..LFSR_WIDTH");
    end
    if (LFSR_WIDTH > LFSR_MAX_WIDTH) begin : g_bad_lfsr
        $error("prng_stream_channel: LFSR_WIDTH exceeds package maximum");
    end

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic [DATA_WIDTH-1:0] push_word;
    lfsr_word_t            work;
    lfsr_step_t            step_r;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    logic push_ok;
    logic pop_ok;
    logic ovf_evt;
    logic unf_evt;

    // DATA_WIDTH LFSR steps unrolled; word bit i is the lsb consumed by step i.
    always_comb begin
        work      = lfsr_word_t'(lfsr_q);
        push_word = '0;
        step_r    = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            step_r       = lfsr_step(work, lfsr_word_t'(POLY));
            push_word[i] = step_r.out_bit;
            work         = step_r.state;
        end
        lfsr_next = work[LFSR_WIDTH-1:0];
    end

    assign valid   = (count != '0);
    assign full    = (count == CW'(FIFO_DEPTH));

    assign push_ok = !full && ((mode == MODE_AUTOFILL) || gen_req);
    assign pop_ok  = pop && valid;
    assign ovf_evt = (mode == MODE_MANUAL) && gen_req && full;
    assign unf_evt = pop && !valid;

    assign data_out = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q    <= SEED;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                lfsr_q <= lfsr_next;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count     <= count + CW'(push_ok) - CW'(pop_ok);
            // A fresh error in the clearing cycle keeps its flag set.
            overflow  <= ovf_evt || (overflow && !clear_err);
            underflow <= unf_evt || (underflow && !clear_err);
        end
    end

    // Storage carries no reset; data_out is blanked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

endmodule

// File: rtl/prng_stream_buffer.sv
// Multi-channel pseudo-random word source: NUM_CH independent LFSR-fed FIFOs,
// each with manual or auto-fill push mode.
module prng_stream_buffer
    import prng_stream_pkg::*;
#(
    parameter int                    NUM_CH     = 2,
    parameter int                    DATA_WIDTH = 4,
    parameter int                    FIFO_DEPTH = 16,
    parameter int                    LFSR_WIDTH = 8,
    parameter int unsigned           LFSR_SEED  = 1,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = LFSR_WIDTH'(DEFAULT_LFSR_POLY),
    localparam int                   CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            mode,
    input  logic [NUM_CH-1:0]            gen_req,
    input  logic [NUM_CH-1:0]            pop,
    input  logic                         clear_err,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            valid,
    output logic [NUM_CH-1:0]            full,
    output logic [NUM_CH*CW-1:0]         count,
    output logic [NUM_CH-1:0]            overflow,
    output logic [NUM_CH-1:0]            underflow
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("prng_stream_buffer: NUM_CH must be >= 1");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Each channel starts from its own seed so streams differ from reset.
        localparam logic [LFSR_WIDTH-1:0] SEED_C = LFSR_WIDTH'(LFSR_SEED + c);

        if (SEED_C == '0) begin : g_zero_seed
            $error("prng_stream_buffer: channel seed wraps to zero");
        end

        prng_stream_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .LFSR_WIDTH (LFSR_WIDTH),
            .SEED       (SEED_C),
            .POLY       (LFSR_POLY)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .mode       (mode_e'(mode[c])),
            .gen_req    (gen_req[c]),
            .pop        (pop[c]),
            .clear_err  (clear_err),
            .data_out   (data_out[c*DATA_WIDTH +: DATA_WIDTH]),
            .valid      (valid[c]),
            .full       (full[c]),
            .count      (count[c*CW +: CW]),
            .overflow   (overflow[c]),
            .underflow  (underflow[c])
        );
    end

endmodule

// File: tb/tb_prng_stream_buffer.sv
// Randomized self-checking bench for prng_stream_buffer against a queue-based model.
module tb_prng_stream_buffer;

    localparam int          NUM_CH = 2;
    localparam int          DW     = 4;
    localparam int          DEPTH  = 16;
    localparam int          LW     = 8;
    localparam int unsigned SEED   = 1;
    localparam int unsigned POLY   = 32'hB8;
    localparam int          CW     = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_CH-1:0]      mode = '0;
    logic [NUM_CH-1:0]      gen_req = '0;
    logic [NUM_CH-1:0]      pop = '0;
    logic                   clear_err = 1'b0;
    logic [NUM_CH*DW-1:0]   data_out;
    logic [NUM_CH-1:0]      valid;
    logic [NUM_CH-1:0]      full;
    logic [NUM_CH*CW-1:0]   count;
    logic [NUM_CH-1:0]      overflow;
    logic [NUM_CH-1:0]      underflow;

    prng_stream_buffer #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .LFSR_WIDTH (LW),
        .LFSR_SEED  (SEED),
        .LFSR_POLY  (8'hB8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .gen_req    (gen_req),
        .pop        (pop),
        .clear_err  (clear_err),
        .data_out   (data_out),
        .valid      (valid),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned m_lfsr [NUM_CH];
    int unsigned m_q    [NUM_CH][$];
    bit          m_ovf  [NUM_CH];
    bit          m_unf  [NUM_CH];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned gen_word(input int c);
        int unsigned w;
        int unsigned b;
        w = 0;
        for (int i = 0; i < DW; i++) begin
            b = m_lfsr[c] & 1;
            m_lfsr[c] = m_lfsr[c] >> 1;
            if (b != 0) m_lfsr[c] = m_lfsr[c] ^ POLY;
            w = w | (b << i);
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_lfsr[c] = (SEED + c) & ((1 << LW) - 1);
            m_q[c].delete();
            m_ovf[c] = 0;
            m_unf[c] = 0;
        end
    endtask

    task automatic model_edge();
        int  sz;
        bit  is_full, is_empty, do_push, do_pop, ovf_set, unf_set;
        int unsigned w;
        for (int c = 0; c < NUM_CH; c++) begin
            sz       = m_q[c].size();
            is_full  = (sz == DEPTH);
            is_empty = (sz == 0);
            do_push  = !is_full && (mode[c] || gen_req[c]);
            do_pop   = pop[c] && !is_empty;
            ovf_set  = !mode[c] && gen_req[c] && is_full;
            unf_set  = pop[c] && is_empty;
            if (do_pop) w = m_q[c].pop_front();
            if (do_push) m_q[c].push_back(gen_word(c));
            m_ovf[c] = ovf_set || (m_ovf[c] && !clear_err);
            m_unf[c] = unf_set || (m_unf[c] && !clear_err);
        end
    endtask

    task automatic check_all();
        int unsigned sz;
        int unsigned head;
        for (int c = 0; c < NUM_CH; c++) begin
            sz   = m_q[c].size();
            head = (sz != 0) ? m_q[c][0] : 0;
            check($sformatf("ch%0d data_out", c), data_out[c*DW +: DW], head);
            check($sformatf("ch%0d count", c), count[c*CW +: CW], sz);
            check($sformatf("ch%0d valid", c), valid[c], (sz != 0));
            check($sformatf("ch%0d full", c), full[c], (sz == DEPTH));
            check($sformatf("ch%0d overflow", c), overflow[c], m_ovf[c]);
            check($sformatf("ch%0d underflow", c), underflow[c], m_unf[c]);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Called just after an active edge: asserts reset between edges so the
    // asynchronous clear is seen before any clock arrives.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_inputs();
        mode      = '0;
        gen_req   = '0;
        pop       = '0;
        clear_err = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Two manual pushes on ch0, then pop twice.
        gen_req = 2'b01;
        step_cycle();
        step_cycle();
        gen_req = '0;
        check("plan1 head0", data_out[3:0], 4'h1);
        check("plan1 count0", count[CW-1:0], 2);
        pop = 2'b01;
        step_cycle();
        check("plan1 pop head0", data_out[3:0], 4'h7);
        step_cycle();
        pop = '0;
        check("plan1 empty valid0", valid[0], 0);
        check("plan1 empty data0", data_out[3:0], 0);

        // Auto-fill ch1 to full.
        clear_inputs();
        async_reset();
        mode = 2'b10;
        repeat (DEPTH) step_cycle();
        check("plan2 count1", count[CW +: CW], DEPTH);
        check("plan2 full1", full[1], 1);
        check("plan2 head1", data_out[DW +: DW], 4'h2);
        check("plan2 count0", count[CW-1:0], 0);
        pop = 2'b10;
        step_cycle();
        pop = '0;
        check("plan3 count1 after pop", count[CW +: CW], DEPTH - 1);
        step_cycle();
        check("plan3 count1 refill", count[CW +: CW], DEPTH);
        check("plan3 no overflow1", overflow[1], 0);

        // Manual overflow on ch0, then clear; clear colliding with a new error.
        clear_inputs();
        async_reset();
        gen_req = 2'b01;
        repeat (DEPTH) step_cycle();
        check("plan4 full0", full[0], 1);
        step_cycle();
        check("plan4 overflow0", overflow[0], 1);
        check("plan4 count0 held", count[CW-1:0], DEPTH);
        clear_err = 1'b1;
        step_cycle();
        check("plan4 clear collide", overflow[0], 1);
        gen_req = '0;
        step_cycle();
        clear_err = 1'b0;
        check("plan4 cleared", overflow[0], 0);

        // Drain, pop on empty, then push+pop on empty.
        pop = 2'b01;
        repeat (DEPTH) step_cycle();
        step_cycle();
        check("plan5 underflow0", underflow[0], 1);
        pop = '0;
        clear_err = 1'b1;
        step_cycle();
        clear_err = 1'b0;
        pop = 2'b01;
        gen_req = 2'b01;
        step_cycle();
        clear_inputs();
        check("plan5 push on empty count", count[CW-1:0], 1);
        check("plan5 push on empty underflow", underflow[0], 1);

        // Reset in the middle of a fill.
        async_reset();
        gen_req = 2'b01;
        repeat (9) step_cycle();
        check("plan6 count9", count[CW-1:0], 9);
        gen_req = '0;
        #2;
        reset = 1'b1;
        #1;
        check("plan6 async count", count, 0);
        check("plan6 async valid", valid, 0);
        check("plan6 async data", data_out, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        gen_req = 2'b01;
        step_cycle();
        gen_req = '0;
        check("plan6 restart head0", data_out[3:0], 4'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) mode = NUM_CH'($urandom);
            gen_req = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++) pop[c] = ($urandom_range(0, 9) < 4);
            clear_err = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
            step_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prng_stream_buffer.md
Name: prng_stream_buffer

Overview:
Multi-channel pseudo-random word source. Each channel is a parallel Galois LFSR that feeds its own first-word-fall-through FIFO.
Generalises the single-channel LFSR-to-FIFO path:
- parametrised channel count, word width and depth
- per-channel manual or auto-fill mode
- occupancy counts and sticky overflow/underflow flags
Sits behind the board button/edge-detect logic and in front of LED or consumer logic.

Parameters:
NUM_CH, 2, number of independent channels (>=1)
DATA_WIDTH, 4, bits produced per accepted push; also the FIFO word width (1..LFSR_WIDTH)
FIFO_DEPTH, 16, entries per channel FIFO; power of two, >=2
LFSR_WIDTH, 8, LFSR state width
LFSR_SEED, 1, channel-0 seed; channel c seed = LFSR_SEED + c (mod 2^LFSR_WIDTH), must be nonzero for every c (elaboration assertion)
LFSR_POLY, 8'hB8, Galois feedback mask, LFSR_WIDTH bits

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
mode  in  NUM_CH  per channel: 0 = manual, 1 = auto-fill
gen_req  in  NUM_CH  manual-mode push request, one word per cycle high
pop  in  NUM_CH  pop head word
data_out  out  NUM_CH*DATA_WIDTH  head word per channel; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
valid  out  NUM_CH  channel FIFO non-empty
full  out  NUM_CH  channel FIFO holds FIFO_DEPTH entries
count  out  NUM_CH*CW  occupancy per channel, CW = clog2(FIFO_DEPTH)+1
overflow  out  NUM_CH  sticky: manual gen_req while full
underflow  out  NUM_CH  sticky: pop while empty
clear_err  in  1  clears all sticky flags

Behaviour:
- Reset (async assert; release synchronous to clk):
  - LFSR_c = seed_c; FIFO pointers 0; count 0
  - valid 0, full 0, overflow 0, underflow 0, data_out 0
- LFSR step: lsb = s[0]; s = s>>1; if lsb, s ^= LFSR_POLY.
- One push:
  - DATA_WIDTH steps combinationally unrolled.
  - Word bit i = lsb of step i.
  - State advances only on an accepted push; otherwise it holds.
- Push accept, evaluated per channel against registered full:
  - manual: gen_req && !full
  - auto-fill: !full (a push every cycle until full)
- Manual gen_req while full: word dropped, LFSR holds, overflow set. Auto-fill never sets overflow; gen_req is ignored in auto-fill.
- Pop accept: pop && valid. Pop while empty: ignored, underflow set.
- Simultaneous push and pop:
  - non-empty and not full: both accepted, count unchanged.
  - empty: push accepted, pop is an underflow (no bypass).
  - full: pop accepted, push not accepted (full is registered); auto-fill refills the next cycle.
- Latency: a push accepted at edge k makes the word visible on data_out/valid after edge k; count updates at the same edge.
- data_out = head entry when valid, else forced to 0 (LED blanking).
- full = (count == FIFO_DEPTH); valid = (count != 0). Pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
- Mode change is sampled each cycle and takes effect on the same edge. FIFO contents are preserved across mode changes.
- clear_err clears all sticky flags. A new error in the same cycle wins: the flag stays set.
- Reset asserted mid-operation discards all FIFO contents and restarts every LFSR from its seed.
- Channels are fully independent; no shared arbitration.

Decomposition:
- Package prng_stream_pkg:
  - mode_e enum (MODE_MANUAL = 0, MODE_AUTOFILL = 1)
  - default polynomial constant
  - lfsr_step function (state, poly) returning next state and output bit
- Sub-module prng_stream_channel: one LFSR, FIFO storage, pointers, count and error flags. Instantiated NUM_CH times in a generate loop.
- The top level only slices the buses and fans out clear_err.

Test Plan:
- Reset release, manual, defaults; gen_req[0] for 1 cycle, then gen_req[0] for 1 cycle -> data_out ch0 = 0x1, count = 2; pop -> 0x7, count = 1; pop -> data_out 0, valid 0.
- Reset release, mode[1] = 1 (auto-fill) -> ch1 count reaches 16 after 16 cycles, full = 1, head = 0x2; ch0 untouched (count 0).
- Ch1 full in auto-fill, pop held 1 cycle -> count 15 for one cycle, then 16; no overflow; head advances to the second word.
- Manual ch0, 16 gen_req -> full; 17th gen_req -> overflow[0] = 1, count 16, later words unaffected (LFSR held); clear_err -> overflow[0] = 0.
- Pop on empty ch0 -> underflow[0] = 1, count 0. Same cycle as gen_req on empty -> word stored (count 1), underflow set.
- Assert reset mid-fill (count 9) -> all outputs 0 immediately (async). After release, first manual word on ch0 = 0x1 again.
